wb_core_ctrl: RTL and testbench

- Wishbone slave control bridge between the Caravel management SoC and the single-cycle RISC-V core inside user_project_wrapper.
- Loads instruction memory word by word, gates the core clock enable (run / halt / single-step) and holds core reset.
- Counts executed cycles and raises an interrupt when the core halts.
- Successor to the LA-only hookup: the register window base address and the IMEM depth are parameters.

---
 rtl/wb_core_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_wb_core_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_core_ctrl.sv
// rtl/wb_core_ctrl.sv - Wishbone control bridge: IMEM loader, run/halt/step gating, cycle counter, halt irq
// Optional breakpoint register is built in when WB_CORE_CTRL_BKPT_EN is defined.
module wb_core_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          IMEM_DEPTH = 256,
  parameter int          AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_dat_i,
  input  logic [31:0]   wbs_adr_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  input  logic [31:0]   core_pc_i,
  input  logic          core_halt_i,
  output logic          core_en_o,
  output logic          core_rst_o,
  output logic          imem_we_o,
  output logic [AW-1:0] imem_addr_o,
  output logic [31:0]   imem_wdata_o,
  output logic          irq_o
);

  typedef enum logic [1:0] {S_HALT = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_ack;
  logic [31:0]   r_dat;
  logic          r_run;
  logic          r_crst;
  logic          r_werr;
  logic          r_en;
  logic          r_irq;
  logic [31:0]   r_cycle;
  logic [AW-1:0] r_ptr;
  logic          r_imem_we;
  logic [AW-1:0] r_imem_addr;
  logic [31:0]   r_imem_wdata;

  logic          w_hit;
  logic          w_wr;
  logic [3:0]    w_off;
  logic          w_wr_ctrl;
  logic          w_wr_status;
  logic          w_wr_cycle;
  logic          w_wr_ptr;
  logic          w_wr_imem;
  logic          w_halted;
  logic          w_irq;
  logic          w_bkpt_trip;
  logic          w_bkhit;
  logic [31:0]   w_bkpt_rd;
  logic [31:0]   w_rdata;
  logic          w_unused;

  // The !r_ack term splits a held strobe into separate one-cycle transactions.
  assign w_hit       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:6] == BASE_ADDR[31:6]) & ~r_ack;
  assign w_wr        = w_hit & wbs_we_i & (wbs_sel_i == 4'hF);
  assign w_off       = wbs_adr_i[5:2];
  assign w_wr_ctrl   = w_wr & (w_off == 4'd0);
  assign w_wr_status = w_wr & (w_off == 4'd1);
  assign w_wr_cycle  = w_wr & (w_off == 4'd2);
  assign w_wr_ptr    = w_wr & (w_off == 4'd3);
  assign w_wr_imem   = w_wr & (w_off == 4'd4);
  assign w_halted    = (r_state == S_HALT);
  assign w_unused    = ^{wbs_adr_i[1:0], core_pc_i};

`ifdef WB_CORE_CTRL_BKPT_EN
  logic [31:0] r_bkpt;
  logic        r_bkhit;

  assign w_bkpt_trip = (r_state == S_RUN) & r_bkpt[0] & (core_pc_i[31:2] == r_bkpt[31:2]);
  assign w_bkhit     = r_bkhit;
  assign w_bkpt_rd   = r_bkpt;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_bkpt  <= 32'd0;
      r_bkhit <= 1'b0;
    end else begin
      if (w_wr && (w_off == 4'd5)) r_bkpt <= wbs_dat_i & 32'hFFFF_FFFD;
      if (w_bkpt_trip) r_bkhit <= 1'b1;
      else if (w_halted && (w_next == S_RUN)) r_bkhit <= 1'b0;
    end
  end
`else
  assign w_bkpt_trip = 1'b0;
  assign w_bkhit     = 1'b0;
  assign w_bkpt_rd   = 32'd0;
`endif

  always_comb begin
    w_next = r_state;
    w_irq  = 1'b0;
    case (r_state)
      S_HALT: begin
        if (w_wr_ctrl && !wbs_dat_i[2]) begin
          if (wbs_dat_i[0]) w_next = S_RUN;
          else if (wbs_dat_i[1]) w_next = S_STEP;
        end
      end
      S_RUN: begin
        if (core_halt_i || w_bkpt_trip || (w_wr_ctrl && (!wbs_dat_i[0] || wbs_dat_i[2]))) begin
          w_next = S_HALT;
          w_irq  = 1'b1;
        end
      end
      default: w_next = S_HALT;
    endcase
  end

  always_comb begin
    w_rdata = 32'd0;
    case (w_off)
      4'd0:    w_rdata = {29'd0, r_crst, 1'b0, r_run};
      4'd1:    w_rdata = {28'd0, r_werr, w_bkhit, w_halted, ~w_halted};
      4'd2:    w_rdata = r_cycle;
      4'd3:    w_rdata = {{(32-AW){1'b0}}, r_ptr};
      4'd5:    w_rdata = w_bkpt_rd;
      default: w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state      <= S_HALT;
      r_ack        <= 1'b0;
      r_dat        <= 32'd0;
      r_run        <= 1'b0;
      r_crst       <= 1'b1;
      r_werr       <= 1'b0;
      r_en         <= 1'b0;
      r_irq        <= 1'b0;
      r_cycle      <= 32'd0;
      r_ptr        <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= 32'd0;
    end else begin
      r_ack   <= w_hit;
      r_dat   <= (w_hit && !wbs_we_i) ? w_rdata : 32'd0;
      r_state <= w_next;
      r_en    <= (w_next != S_HALT);
      r_irq   <= w_irq;

      if (w_wr_ctrl) begin
        r_run  <= wbs_dat_i[0];
        r_crst <= wbs_dat_i[2];
      end
      if ((r_state == S_RUN) && (w_next == S_HALT)) r_run <= 1'b0;

      if (w_wr_cycle) r_cycle <= 32'd0;
      else if (r_en) r_cycle <= r_cycle + 32'd1;

      if (w_wr_status && wbs_dat_i[3]) r_werr <= 1'b0;
      else if (w_wr_imem && !w_halted) r_werr <= 1'b1;

      // IMEM is only written while the core is stopped; the pointer wraps naturally.
      r_imem_we <= w_wr_imem & w_halted;
      if (w_wr_ptr) begin
        r_ptr <= wbs_dat_i[AW-1:0];
      end else if (w_wr_imem && w_halted) begin
        r_ptr        <= r_ptr + 1'b1;
        r_imem_addr  <= r_ptr;
        r_imem_wdata <= wbs_dat_i;
      end
    end
  end

  assign wbs_ack_o    = r_ack;
  assign wbs_dat_o    = r_dat;
  assign core_en_o    = r_en;
  assign core_rst_o   = r_crst;
  assign irq_o        = r_irq;
  assign imem_we_o    = r_imem_we;
  assign imem_addr_o  = r_imem_addr;
  assign imem_wdata_o = r_imem_wdata;

endmodule

// File: tb/tb_wb_core_ctrl.sv
// tb/tb_wb_core_ctrl.sv - scoreboard bench for wb_core_ctrl with a transaction-level reference model
// Breakpoint checks are built in when WB_CORE_CTRL_BKPT_EN is defined.
module tb_wb_core_ctrl;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DEPTH = 256;
  localparam int          AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stb = 1'b0, bcyc = 1'b0, we = 1'b0;
  logic [3:0]    sel = 4'h0;
  logic [31:0]   dat_i = 32'd0, adr = 32'd0, pc = 32'd0;
  logic          halt_i = 1'b0;
  logic          ack, en, crst_o, imem_we, irq;
  logic [31:0]   dat_o, imem_wdata;
  logic [AW-1:0] imem_addr;

  wb_core_ctrl #(.BASE_ADDR(BASE), .IMEM_DEPTH(DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(bcyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .core_pc_i(pc), .core_halt_i(halt_i), .core_en_o(en), .core_rst_o(crst_o),
    .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct { bit chk; logic [31:0] dat; string name; } rd_exp_t;
  typedef struct { logic [AW-1:0] addr; logic [31:0] dat; } im_exp_t;
  rd_exp_t rd_q[$];
  im_exp_t im_q[$];

  int n_checks = 0, n_fail = 0;
  int irq_seen = 0, en_seen = 0;

  // Reference model: state at transaction level, time measured in clock edges.
  bit          m_running = 0, m_run = 0, m_crst = 1, m_werr = 0, m_bkhit = 0;
  logic [31:0] m_acc = 0, m_bkpt = 0;
  int          m_start = 0, m_en_total = 0, m_irqs = 0, m_ptr = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void enter_run(input int p);
    m_running = 1; m_start = p; m_bkhit = 0;
  endfunction

  function automatic void leave_run(input int p);
    m_acc = m_acc + 32'(p - m_start);
    m_en_total += p - m_start;
    m_running = 0; m_run = 0; m_irqs++;
  endfunction

  function automatic void model_write(input logic [5:0] off, input logic [31:0] d,
                                      input logic [3:0] s, input int p);
    if (s != 4'hF) return;
    case (off[5:2])
      4'd0: begin
        if (m_running) begin
          if (!d[0] || d[2]) leave_run(p);
        end else begin
          m_run = d[0];
          if (!d[2] && d[0]) enter_run(p);
          else if (!d[2] && d[1]) begin m_acc = m_acc + 1; m_en_total++; end
        end
        m_crst = d[2];
      end
      4'd1: if (d[3]) m_werr = 0;
      4'd2: begin
        if (m_running) begin m_en_total += p - m_start; m_start = p; end
        m_acc = 0;
      end
      4'd3: m_ptr = int'(d[AW-1:0]);
      4'd4: begin
        if (!m_running) begin
          im_q.push_back('{addr: AW'(m_ptr), dat: d});
          m_ptr = (m_ptr + 1) % DEPTH;
        end else m_werr = 1;
      end
`ifdef WB_CORE_CTRL_BKPT_EN
      4'd5: m_bkpt = d & 32'hFFFF_FFFD;
`endif
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] off, input int p);
    case (off[5:2])
      4'd0: return {29'd0, m_crst, 1'b0, m_run};
      4'd1: return {28'd0, m_werr, m_bkhit, !m_running, m_running};
      4'd2: return m_running ? m_acc + 32'(p - 1 - m_start) : m_acc;
      4'd3: return 32'(m_ptr);
`ifdef WB_CORE_CTRL_BKPT_EN
      4'd5: return m_bkpt;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    stb = 1; bcyc = 1; we = w; adr = a; dat_i = d; sel = s;
    @(negedge clk);
    stb = 0; bcyc = 0; we = 0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [5:0] off, input logic [31:0] d, input logic [3:0] s = 4'hF);
    model_write(off, d, s, edge_cnt + 1);
    rd_q.push_back('{chk: 1'b0, dat: 32'd0, name: "write"});
    bus(1'b1, BASE + {26'd0, off}, d, s);
  endtask

  task automatic rd(input logic [5:0] off, input string nm);
    rd_q.push_back('{chk: 1'b1, dat: model_read(off, edge_cnt + 1), name: nm});
    bus(1'b0, BASE + {26'd0, off}, 32'd0, 4'hF);
  endtask

  task automatic miss(input logic [31:0] a, input logic c);
    stb = 1; bcyc = c; we = 1; adr = a; dat_i = 32'd1; sel = 4'hF;
    repeat (3) @(negedge clk);
    stb = 0; bcyc = 0; we = 0;
    @(negedge clk);
  endtask

  task automatic check_pins(input string tag);
    @(negedge clk);
    #1;
    check({tag, "_core_en"}, 32'(en), 32'(m_running));
    check({tag, "_core_rst"}, 32'(crst_o), 32'(m_crst));
    check({tag, "_irq_count"}, irq_seen, m_irqs);
    if (!m_running) check({tag, "_en_cycles"}, en_seen, m_en_total);
  endtask

  initial begin : monitor
    bit prev_ack = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ack) begin
          check("ack_single_cycle", 32'(prev_ack), 32'd0);
          if (rd_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_ack: actual=ack required=no ack at %0t", $time);
          end else begin
            rd_exp_t e;
            e = rd_q.pop_front();
            if (e.chk) check(e.name, dat_o, e.dat);
          end
        end else begin
          check("dat_idle_zero", dat_o, 32'd0);
        end
        if (imem_we) begin
          if (im_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_imem_we: actual=we addr %h required=no write", imem_addr);
          end else begin
            im_exp_t m;
            m = im_q.pop_front();
            check("imem_addr", 32'(imem_addr), 32'(m.addr));
            check("imem_wdata", imem_wdata, m.dat);
          end
        end
        if (irq) irq_seen++;
        if (en) en_seen++;
        prev_ack = ack;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int p;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_dat", dat_o, 0);
    check("rst_core_en", 32'(en), 0);
    check("rst_core_rst", 32'(crst_o), 1);
    check("rst_imem_we", 32'(imem_we), 0);
    check("rst_imem_addr", 32'(imem_addr), 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst_irq", 32'(irq), 0);
    rst = 0;
    #1;
    check("release_core_rst", 32'(crst_o), 1);
    check("release_core_en", 32'(en), 0);
    @(negedge clk);

    rd(6'h04, "status_after_reset");
    check_pins("reset");
    rd(6'h00, "ctrl_after_reset");

    wr(6'h00, 32'd0);
    wr(6'h0C, 32'h0000_00FE);
    wr(6'h10, 32'hAAAA_0001);
    wr(6'h10, 32'hBBBB_0002);
    rd(6'h0C, "imem_ptr_wrap");

    wr(6'h08, 32'd0);
    wr(6'h00, 32'd1);
    repeat (10) @(negedge clk);
    wr(6'h00, 32'd0);
    rd(6'h08, "cycle_after_run");
    rd(6'h04, "status_after_run");
    check_pins("run10");

    wr(6'h00, 32'd2);
    wr(6'h00, 32'd2);
    rd(6'h08, "cycle_after_steps");
    check_pins("steps");

    wr(6'h00, 32'd1);
    repeat (3) @(negedge clk);
    halt_i = 1;
    leave_run(edge_cnt + 1);
    @(negedge clk);
    halt_i = 0;
    rd(6'h00, "ctrl_after_core_halt");
    check_pins("core_halt");

    wr(6'h00, 32'd1);
    wr(6'h10, 32'h1234_5678);
    rd(6'h04, "status_wr_err");
    wr(6'h00, 32'd0);
    wr(6'h04, 32'd8);
    rd(6'h04, "status_err_cleared");
    check_pins("wr_err");

    wr(6'h00, 32'd1, 4'h3);
    rd(6'h00, "ctrl_partial_sel");
    check_pins("partial_sel");

    p = edge_cnt + 1;
    rd_q.push_back('{chk: 1'b1, dat: model_read(6'h04, p), name: "held_strobe_1"});
    rd_q.push_back('{chk: 1'b1, dat: model_read(6'h04, p + 2), name: "held_strobe_2"});
    stb = 1; bcyc = 1; we = 0; adr = BASE + 32'h4;
    repeat (4) @(negedge clk);
    stb = 0; bcyc = 0;
    @(negedge clk);

    miss(BASE + 32'h40, 1'b1);
    miss(BASE - 32'h40, 1'b1);
    miss(BASE, 1'b0);
    check_pins("misses");

`ifdef WB_CORE_CTRL_BKPT_EN
    wr(6'h14, 32'h0000_0101);
    pc = 32'h0000_0100;
    p = edge_cnt + 1;
    wr(6'h00, 32'd1);
    leave_run(p + 1);
    m_bkhit = 1;
    rd(6'h04, "status_bkpt_hit");
    rd(6'h14, "bkpt_readback");
    check_pins("bkpt");
    pc = 32'd0;
    wr(6'h14, 32'd0);
    wr(6'h00, 32'd1);
    rd(6'h04, "status_bkpt_cleared");
    wr(6'h00, 32'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: wr(6'h00, $urandom & 32'h7, ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF);
        1: rd({4'($urandom_range(0, 15)), 2'b00}, "rand_read");
        2: wr(6'h0C, $urandom);
        3: wr(6'h10, $urandom);
        4: wr(6'h08, $urandom);
        5: wr(6'h04, $urandom);
        6: repeat ($urandom_range(1, 5)) @(negedge clk);
        7: miss(BASE + 32'h40 + ($urandom & 32'h3C), 1'b1);
        8: wr({4'($urandom_range(6, 15)), 2'b00}, $urandom);
        default: wr(6'h14, $urandom & 32'hFFFF_FFFE);
      endcase
    end

    if (m_running) wr(6'h00, 32'd0);
    rd(6'h08, "cycle_final");
    rd(6'h04, "status_final");
    check_pins("final");
    check("rd_queue_drained", rd_q.size(), 0);
    check("imem_queue_drained", im_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
